// File: rtl/coin_credit_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// coin_credit_accumulator_pkg
//   Shared definitions for the coin credit accumulator:
//     state_t        - grant FSM state encoding
//     *_CENTS        - value of each coin type in cents
// ---------------------------------------------------------------------------
package coin_credit_accumulator_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      GRANT     = 2'd1,
      WAIT_PASS = 2'd2
   } state_t;

   localparam int NICKEL_CENTS  = 5;
   localparam int DIME_CENTS    = 10;
   localparam int QUARTER_CENTS = 25;

endpackage

// File: rtl/coin_credit_accumulator_debounce_filter.sv
// ---------------------------------------------------------------------------
// debounce_filter
//   Conditions one raw, asynchronous, bouncy sensor line: a two-flop
//   synchronizer, a stability counter, a debounced level, and a one-cycle
//   pulse on each rising edge of that level (falling edges are ignored).
//
//   Ports:
//     i_Clk      in   system clock
//     i_Reset_n  in   asynchronous active-low reset
//     i_Raw      in   raw sensor input (active high)
//     o_Rise     out  one-cycle pulse when the debounced level goes 0 -> 1
// ---------------------------------------------------------------------------
module debounce_filter #(
   parameter int DEBOUNCE_LIMIT = 250000
) (
   input  logic i_Clk,
   input  logic i_Reset_n,
   input  logic i_Raw,
   output logic o_Rise
);

   localparam int                CNT_W    = $clog2(DEBOUNCE_LIMIT);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

   logic             sync_1;
   logic             sync_2;
   logic             level;
   logic             level_d;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         sync_1  <= 1'b0;
         sync_2  <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         cnt     <= '0;
      end else begin
         sync_1  <= i_Raw;
         sync_2  <= sync_1;
         level_d <= level;
         // Count consecutive clocks of disagreement; any agreement restarts
         // the count, so a bounce shorter than the limit never toggles.
         if (sync_2 != level) begin
            if (cnt == CNT_LAST) begin
               level <= sync_2;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign o_Rise = level & ~level_d;

endmodule

// File: rtl/coin_credit_accumulator.sv
// ---------------------------------------------------------------------------
// coin_credit_accumulator
//   Debounces three coin sensors, accumulates credit in cents (saturating at
//   MAX_CREDIT) and grants one turnstile passage per FARE of credit.
//
//   Ports:
//     i_Clk       in   system clock
//     i_Reset_n   in   asynchronous active-low reset
//     i_Nickel    in   raw nickel sensor (5 cents)
//     i_Dime      in   raw dime sensor (10 cents)
//     i_Quarter   in   raw quarter sensor (25 cents)
//     i_Locked    in   turnstile lock status (1 = locked)
//     o_Coin      out  passage grant level to the turnstile
//     o_Credit    out  current credit in cents
//     o_Overflow  out  one-cycle pulse when a deposit is clipped
//     o_State     out  debug view of the grant FSM state (state_t encoding)
//
//   Grant handshake: o_Coin rises when a fare is taken from credit and stays
//   high until the turnstile answers with i_Locked=0 (unlocked); the FSM then
//   waits for i_Locked=1 (relocked) before another fare can be taken, so two
//   grants are always separated by a full unlock/relock cycle.
// ---------------------------------------------------------------------------
module coin_credit_accumulator
   import coin_credit_accumulator_pkg::*;
#(
   parameter int DEBOUNCE_LIMIT = 250000,
   parameter int FARE           = 25,
   parameter int MAX_CREDIT     = 200,
   parameter int CREDIT_WIDTH   = 8
) (
   input  logic                    i_Clk,
   input  logic                    i_Reset_n,
   input  logic                    i_Nickel,
   input  logic                    i_Dime,
   input  logic                    i_Quarter,
   input  logic                    i_Locked,
   output logic                    o_Coin,
   output logic [CREDIT_WIDTH-1:0] o_Credit,
   output logic                    o_Overflow,
   output logic [1:0]              o_State
);

   // Arithmetic is one bit wider than the credit register so a deposit on
   // top of a near-full credit can be seen exceeding the ceiling.
   localparam int                  SUM_W     = CREDIT_WIDTH + 1;
   localparam logic [SUM_W-1:0]    FARE_W    = SUM_W'(FARE);
   localparam logic [SUM_W-1:0]    MAX_W     = SUM_W'(MAX_CREDIT);
   localparam logic [SUM_W-1:0]    NICKEL_W  = SUM_W'(NICKEL_CENTS);
   localparam logic [SUM_W-1:0]    DIME_W    = SUM_W'(DIME_CENTS);
   localparam logic [SUM_W-1:0]    QUARTER_W = SUM_W'(QUARTER_CENTS);

   logic nickel_rise;
   logic dime_rise;
   logic quarter_rise;

   state_t                  state_q;
   state_t                  state_next;
   logic [CREDIT_WIDTH-1:0] credit_q;
   logic                    coin_q;
   logic                    overflow_q;
   logic [SUM_W-1:0]        add;
   logic [SUM_W-1:0]        deduct;
   logic [SUM_W-1:0]        credit_sum;

   debounce_filter #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_nickel (
      .i_Clk     (i_Clk),
      .i_Reset_n (i_Reset_n),
      .i_Raw     (i_Nickel),
      .o_Rise    (nickel_rise)
   );

   debounce_filter #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_dime (
      .i_Clk     (i_Clk),
      .i_Reset_n (i_Reset_n),
      .i_Raw     (i_Dime),
      .o_Rise    (dime_rise)
   );

   debounce_filter #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_quarter (
      .i_Clk     (i_Clk),
      .i_Reset_n (i_Reset_n),
      .i_Raw     (i_Quarter),
      .o_Rise    (quarter_rise)
   );

   // Simultaneous coin pulses are summed in the same cycle.
   always_comb begin
      add = '0;
      if (nickel_rise)  add = add + NICKEL_W;
      if (dime_rise)    add = add + DIME_W;
      if (quarter_rise) add = add + QUARTER_W;
   end

   // Grant FSM; the fare is deducted in the same cycle the FSM leaves IDLE.
   always_comb begin
      state_next = state_q;
      deduct     = '0;
      case (state_q)
         IDLE: begin
            if (({1'b0, credit_q} >= FARE_W) && i_Locked) begin
               state_next = GRANT;
               deduct     = FARE_W;
            end
         end
         GRANT: begin
            if (!i_Locked) state_next = WAIT_PASS;
         end
         WAIT_PASS: begin
            if (i_Locked) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Cannot underflow: a deduction only happens with credit >= FARE.
   assign credit_sum = {1'b0, credit_q} + add - deduct;

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q    <= IDLE;
         credit_q   <= '0;
         coin_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q <= state_next;
         coin_q  <= (state_next == GRANT);
         if (credit_sum > MAX_W) begin
            credit_q   <= MAX_W[CREDIT_WIDTH-1:0];
            overflow_q <= 1'b1;
         end else begin
            credit_q   <= credit_sum[CREDIT_WIDTH-1:0];
            overflow_q <= 1'b0;
         end
      end
   end

   assign o_Coin     = coin_q;
   assign o_Credit   = credit_q;
   assign o_Overflow = overflow_q;
   assign o_State    = state_q;

endmodule

// File: tb/tb_coin_credit_accumulator.sv
// ---------------------------------------------------------------------------
// tb_coin_credit_accumulator
//   Self-checking bench for coin_credit_accumulator with DEBOUNCE_LIMIT=4,
//   FARE=25, MAX_CREDIT=200. Every credit value the DUT should show is pushed
//   to exp_q when the stimulus is driven; a monitor pops and compares on each
//   change of o_Credit. Scenario tasks add inline checks of o_Coin,
//   o_Overflow and the FSM state.
// ---------------------------------------------------------------------------
module tb_coin_credit_accumulator;
   import coin_credit_accumulator_pkg::*;

   localparam int CW = 8;

   // ---------------- clock / reset ----------------
   logic clk     = 1'b0;
   logic rst_n   = 1'b0;
   logic nickel  = 1'b0;
   logic dime    = 1'b0;
   logic quarter = 1'b0;
   logic locked  = 1'b0;

   logic          coin;
   logic [CW-1:0] credit;
   logic          ovf;
   logic [1:0]    state;

   always #5 clk = ~clk;

   coin_credit_accumulator #(
      .DEBOUNCE_LIMIT (4),
      .FARE           (25),
      .MAX_CREDIT     (200),
      .CREDIT_WIDTH   (CW)
   ) dut (
      .i_Clk      (clk),
      .i_Reset_n  (rst_n),
      .i_Nickel   (nickel),
      .i_Dime     (dime),
      .i_Quarter  (quarter),
      .i_Locked   (locked),
      .o_Coin     (coin),
      .o_Credit   (credit),
      .o_Overflow (ovf),
      .o_State    (state)
   );

   // ---------------- scoreboard ----------------
   int            checks    = 0;
   int            errors    = 0;
   int            ovf_count = 0;
   logic [CW-1:0] exp_q[$];
   logic [CW-1:0] last_credit = '0;
   logic [CW-1:0] exp_val;

   always @(negedge clk) begin
      if (ovf === 1'b1) ovf_count++;
      if (!rst_n) begin
         last_credit = credit;
      end else if (credit !== last_credit) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL credit_unexpected got %0d want no change from %0d", credit, last_credit);
         end else begin
            exp_val = exp_q.pop_front();
            if (credit !== exp_val) begin
               errors++;
               $display("FAIL credit_sequence got %0d want %0d", credit, exp_val);
            end
         end
         last_credit = credit;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      nickel  = 1'b0;
      dime    = 1'b0;
      quarter = 1'b0;
      locked  = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      exp_q.delete();
      rst_n = 1'b1;
   endtask

   task automatic deposit(input logic n, input logic d, input logic q);
      @(negedge clk);
      nickel  = n;
      dime    = d;
      quarter = q;
      tick(10);
      nickel  = 1'b0;
      dime    = 1'b0;
      quarter = 1'b0;
      tick(10);
   endtask

   task automatic wait_coin(input logic v);
      for (int i = 0; i < 40 && coin !== v; i++) @(negedge clk);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (coin !== 1'b0 || credit !== 8'd0 || ovf !== 1'b0 || state !== 2'd0) begin
         errors++;
         $display("FAIL reset_hold got coin=%0b credit=%0d ovf=%0b state=%0d want 0 0 0 0", coin, credit, ovf, state);
      end
      do_reset();
      tick(2);
      checks++;
      if (coin !== 1'b0) begin errors++; $display("FAIL reset_coin got %0b want 0", coin); end
      checks++;
      if (credit !== 8'd0) begin errors++; $display("FAIL reset_credit got %0d want 0", credit); end
      checks++;
      if (ovf !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", ovf); end
      checks++;
      if (state !== 2'(IDLE)) begin errors++; $display("FAIL reset_state got %0d want %0d", state, IDLE); end
   endtask

   task automatic test_debounce();
      do_reset();
      locked = 1'b0;
      repeat (3) begin
         @(negedge clk);
         dime = ~dime;
      end
      @(negedge clk);
      dime = 1'b0;
      tick(15);
      checks++;
      if (credit !== 8'd0) begin errors++; $display("FAIL bounce_rejected got %0d want 0", credit); end
      exp_q.push_back(8'd10);
      @(negedge clk);
      dime = 1'b1;
      tick(30);
      dime = 1'b0;
      tick(10);
      checks++;
      if (credit !== 8'd10) begin errors++; $display("FAIL long_hold_once got %0d want 10", credit); end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL debounce_pending got %0d want 0 entries", exp_q.size()); end
   endtask

   task automatic test_single_grant();
      do_reset();
      locked = 1'b1;
      exp_q.push_back(8'd10);
      deposit(1'b0, 1'b1, 1'b0);
      exp_q.push_back(8'd20);
      deposit(1'b0, 1'b1, 1'b0);
      exp_q.push_back(8'd25);
      exp_q.push_back(8'd0);
      deposit(1'b1, 1'b0, 1'b0);
      wait_coin(1'b1);
      checks++;
      if (coin !== 1'b1 || state !== 2'(GRANT)) begin
         errors++;
         $display("FAIL single_grant got coin=%0b state=%0d want 1 %0d", coin, state, GRANT);
      end
      checks++;
      if (credit !== 8'd0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL single_grant_credit got %0d (pending %0d) want 0", credit, exp_q.size());
      end
      locked = 1'b0;
      tick(2);
      checks++;
      if (coin !== 1'b0 || state !== 2'(WAIT_PASS)) begin
         errors++;
         $display("FAIL unlock got coin=%0b state=%0d want 0 %0d", coin, state, WAIT_PASS);
      end
      locked = 1'b1;
      tick(2);
      checks++;
      if (coin !== 1'b0 || state !== 2'(IDLE)) begin
         errors++;
         $display("FAIL relock got coin=%0b state=%0d want 0 %0d", coin, state, IDLE);
      end
   endtask

   task automatic test_multi_grant();
      logic [CW-1:0] after_grant;
      do_reset();
      locked = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         exp_q.push_back(8'(25 * i));
         deposit(1'b0, 1'b0, 1'b1);
      end
      wait_drain();
      checks++;
      if (credit !== 8'd75) begin errors++; $display("FAIL three_quarters got %0d want 75", credit); end
      for (int g = 0; g < 3; g++) begin
         after_grant = 8'(75 - 25 * (g + 1));
         exp_q.push_back(after_grant);
         locked = 1'b1;
         wait_coin(1'b1);
         wait_drain();
         checks++;
         if (coin !== 1'b1 || credit !== after_grant) begin
            errors++;
            $display("FAIL grant_%0d got coin=%0b credit=%0d want 1 %0d", g, coin, credit, after_grant);
         end
         locked = 1'b0;
         tick(3);
         checks++;
         if (coin !== 1'b0) begin errors++; $display("FAIL grant_%0d_release got %0b want 0", g, coin); end
      end
      locked = 1'b1;
      tick(6);
      checks++;
      if (coin !== 1'b0 || state !== 2'(IDLE)) begin
         errors++;
         $display("FAIL no_fourth_grant got coin=%0b state=%0d want 0 %0d", coin, state, IDLE);
      end
      locked = 1'b0;
      exp_q.push_back(8'd40);
      deposit(1'b1, 1'b1, 1'b1);
      wait_drain();
      checks++;
      if (credit !== 8'd40) begin errors++; $display("FAIL simultaneous_sum got %0d want 40", credit); end
   endtask

   task automatic test_overflow();
      int base;
      do_reset();
      locked = 1'b1;
      exp_q.push_back(8'd25);
      exp_q.push_back(8'd0);
      deposit(1'b0, 1'b0, 1'b1);
      wait_coin(1'b1);
      locked = 1'b0;
      tick(3);
      checks++;
      if (state !== 2'(WAIT_PASS)) begin errors++; $display("FAIL ovf_setup_state got %0d want %0d", state, WAIT_PASS); end
      for (int i = 1; i <= 7; i++) begin
         exp_q.push_back(8'(25 * i));
         deposit(1'b0, 1'b0, 1'b1);
      end
      exp_q.push_back(8'd185);
      deposit(1'b0, 1'b1, 1'b0);
      exp_q.push_back(8'd190);
      deposit(1'b1, 1'b0, 1'b0);
      checks++;
      if (credit !== 8'd190 || ovf_count != 0) begin
         errors++;
         $display("FAIL preload got credit=%0d ovf_cycles=%0d want 190 0", credit, ovf_count);
      end
      base = ovf_count;
      exp_q.push_back(8'd200);
      deposit(1'b0, 1'b0, 1'b1);
      checks++;
      if (credit !== 8'd200) begin errors++; $display("FAIL saturate got %0d want 200", credit); end
      checks++;
      if (ovf_count - base != 1) begin errors++; $display("FAIL overflow_pulse got %0d cycles want 1", ovf_count - base); end
      base = ovf_count;
      deposit(1'b0, 1'b1, 1'b0);
      checks++;
      if (credit !== 8'd200 || ovf_count - base != 1) begin
         errors++;
         $display("FAIL at_ceiling got credit=%0d ovf_cycles=%0d want 200 1", credit, ovf_count - base);
      end
      exp_q.push_back(8'd175);
      locked = 1'b1;
      wait_coin(1'b1);
      wait_drain();
      checks++;
      if (coin !== 1'b1 || credit !== 8'd175) begin
         errors++;
         $display("FAIL grant_from_ceiling got coin=%0b credit=%0d want 1 175", coin, credit);
      end
   endtask

   task automatic test_grant_deposit();
      do_reset();
      locked = 1'b1;
      exp_q.push_back(8'd25);
      exp_q.push_back(8'd0);
      deposit(1'b0, 1'b0, 1'b1);
      wait_coin(1'b1);
      exp_q.push_back(8'd5);
      deposit(1'b1, 1'b0, 1'b0);
      wait_drain();
      checks++;
      if (coin !== 1'b1 || state !== 2'(GRANT) || credit !== 8'd5) begin
         errors++;
         $display("FAIL deposit_in_grant got coin=%0b state=%0d credit=%0d want 1 %0d 5", coin, state, credit, GRANT);
      end
      locked = 1'b0;
      tick(3);
      locked = 1'b1;
      tick(6);
      checks++;
      if (coin !== 1'b0 || credit !== 8'd5) begin
         errors++;
         $display("FAIL below_fare got coin=%0b credit=%0d want 0 5", coin, credit);
      end
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      locked = 1'b1;
      exp_q.push_back(8'd10);
      deposit(1'b0, 1'b1, 1'b0);
      exp_q.push_back(8'd35);
      exp_q.push_back(8'd10);
      deposit(1'b0, 1'b0, 1'b1);
      wait_coin(1'b1);
      wait_drain();
      checks++;
      if (coin !== 1'b1 || credit !== 8'd10) begin
         errors++;
         $display("FAIL pre_reset_grant got coin=%0b credit=%0d want 1 10", coin, credit);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (coin !== 1'b0 || credit !== 8'd0 || state !== 2'(IDLE)) begin
         errors++;
         $display("FAIL async_reset got coin=%0b credit=%0d state=%0d want 0 0 0", coin, credit, state);
      end
      do_reset();
      locked = 1'b1;
      tick(5);
      checks++;
      if (coin !== 1'b0 || credit !== 8'd0) begin
         errors++;
         $display("FAIL after_reset got coin=%0b credit=%0d want 0 0", coin, credit);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_debounce();
      test_single_grant();
      test_multi_grant();
      test_overflow();
      test_grant_deposit();
      test_reset_mid_grant();
      tick(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
